button_debouncer: RTL
=====================

// Module: button_debouncer
// PURPOSE
//  Input-side counterpart to the board LED drivers. Reads one raw pushbutton on the 100 MHz board clock.
//  Synchronises and debounces it, then reports the clean level, press/release pulses, a long-press event
//  and a wrapping press counter. Instantiated once per board button; outputs feed LED/control logic.
// PARAMETERS
//  DEBOUNCE_CYCLES    1_000_000    consecutive stable cycles needed to commit a level change (10 ms); must be >= 2
//  LONG_PRESS_CYCLES  100_000_000  cycles pressed, counted from press commit, before long_press fires (1 s); >= 1
//  CNT_W              32           width of debounce and hold counters; must hold both cycle counts
//  PRESS_CNT_W        8            width of press_count
// PORTS
//  clk            in   1            board clock, 100 MHz, rising edge
//  rst            in   1            asynchronous, active-high reset
//  btn_in         in   1            raw pushbutton, asynchronous, bouncy, 1 = pressed
//  btn_level      out  1            debounced level, 1 = pressed
//  press_pulse    out  1            1-cycle pulse on the cycle btn_level rises
//  release_pulse  out  1            1-cycle pulse on the cycle btn_level falls
//  long_press     out  1            1-cycle pulse when a press reaches LONG_PRESS_CYCLES
//  held           out  1            level; 1 from long_press until release commit
//  press_count    out  PRESS_CNT_W  number of committed presses, modulo 2^PRESS_CNT_W
// BEHAVIOUR
//  - Reset: all outputs 0, both synchroniser flops 0, counters 0, state IDLE. Reset mid-press aborts everything.
//  - Synchroniser: 2 flops (btn_in -> s1 -> s2). Only s2 is used downstream.
//  - FSM, all registered:
//    IDLE: s2=1 -> PRESS_WAIT, deb_cnt<=0.
//    PRESS_WAIT: s2=0 -> IDLE. Else if deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED, btn_level<=1, press_pulse<=1,
//      press_count+1, hold_cnt<=0. Else deb_cnt+1.
//    PRESSED: s2=0 -> RELEASE_WAIT, deb_cnt<=0. hold_cnt advances every cycle (see below).
//    RELEASE_WAIT: s2=1 -> PRESSED (glitch rejected, no pulses). Else if deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE,
//      btn_level<=0, release_pulse<=1, held<=0, hold_cnt<=0. Else deb_cnt+1.
//  - Press latency: btn_in high at sampling edge k with no bounce -> press_pulse high in the cycle after edge
//    k+DEBOUNCE_CYCLES+2. Release latency is symmetric.
//  - Any bounce shorter than DEBOUNCE_CYCLES restarts qualification from IDLE/PRESSED; partial counts are discarded.
//  - hold_cnt: increments every cycle in PRESSED and RELEASE_WAIT.
//    A rejected release glitch does not clear it.
//    When hold_cnt==LONG_PRESS_CYCLES-1 and held=0: long_press<=1 for one cycle, held<=1.
//    hold_cnt then saturates; long_press fires at most once per press.
//  - Release commit on the same cycle as the long-press threshold: release wins; long_press is not issued.
//  - press_count wraps (2^PRESS_CNT_W-1 -> 0) silently.
//    press_pulse and release_pulse are never high together and are never high on consecutive cycles.
//  - Button held through reset deassertion: treated as a new press; press_pulse after DEBOUNCE_CYCLES+2 cycles.
// TESTING
//  (bench params: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, PRESS_CNT_W=8)
//  1 Clean press: btn_in 0->1, held high.
//    -> press_pulse exactly 1 cycle, 6 cycles after the first sampling edge.
//    -> btn_level=1, press_count=1.
//  2 Bounce: btn_in toggles 1,0,1,1,0 (1-cycle widths), then steady 1.
//    -> no pulse during bounce; one press_pulse 6 cycles after steady 1 begins.
//  3 Long press: hold 30 cycles past press_pulse.
//    -> long_press single pulse 20 cycles after press_pulse; held=1 until release.
//    -> release: release_pulse 1 cycle; held=0, btn_level=0.
//  4 Release glitch: while pressed, btn_in low for 2 cycles.
//    -> no release_pulse; btn_level stays 1; long_press timing unchanged.
//  5 Wrap: 256 clean presses from reset -> press_count reads 0; 255 after the 255th press.
//  6 Reset mid-press: assert rst in PRESS_WAIT and again with held=1.
//    -> all outputs 0 immediately (asynchronous).
//    -> with btn_in still 1, a fresh press_pulse 6 cycles after rst deasserts.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser plus debounce FSM for one raw pushbutton.
// Reports the clean level, press/release pulses, a single long-press event with
// a held level, and a wrapping count of committed presses. All outputs are flops.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
  parameter int unsigned CNT_W             = 32,
  parameter int unsigned PRESS_CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_in,
  output logic                   btn_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_press,
  output logic                   held,
  output logic [PRESS_CNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Terminal counts: a level change commits once deb_cnt reaches DEB_LAST,
  // long_press fires once hold_cnt reaches LONG_LAST.
  localparam logic [CNT_W-1:0]       DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]       LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRESS_CNT_W-1:0] PCNT_ONE  = {{(PRESS_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   s1_q, s1_d;
  logic                   s2_q, s2_d;
  logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   btn_level_q, btn_level_d;
  logic                   press_pulse_q, press_pulse_d;
  logic                   release_pulse_q, release_pulse_d;
  logic                   long_press_q, long_press_d;
  logic                   held_q, held_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;
  logic                   hold_tick_s;

  // Next-state logic: synchroniser shift, debounce FSM and hold timer.
  always_comb begin
    s1_d            = btn_in;
    s2_d            = s1_q;
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    btn_level_d     = btn_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_press_d    = 1'b0;
    held_d          = held_q;
    press_count_d   = press_count_q;
    hold_tick_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = CNT_ZERO;
        end else begin
          state_d   = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d       = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d       = PRESSED;
          btn_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + PCNT_ONE;
          hold_cnt_d    = CNT_ZERO;
        end else begin
          deb_cnt_d     = deb_cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        hold_tick_s = 1'b1;
        if (!s2_q) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = CNT_ZERO;
        end else begin
          state_d   = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          // Release glitch: return to PRESSED, hold timer keeps running.
          state_d     = PRESSED;
          hold_tick_s = 1'b1;
        end else if (deb_cnt_q == DEB_LAST) begin
          // Release commit overrides a long-press threshold on the same cycle.
          state_d         = IDLE;
          btn_level_d     = 1'b0;
          release_pulse_d = 1'b1;
          held_d          = 1'b0;
          hold_cnt_d      = CNT_ZERO;
        end else begin
          deb_cnt_d   = deb_cnt_q + CNT_ONE;
          hold_tick_s = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        deb_cnt_d   = CNT_ZERO;
        hold_cnt_d  = CNT_ZERO;
        btn_level_d = 1'b0;
        held_d      = 1'b0;
      end
    endcase

    // Hold timer saturates at the threshold so long_press fires once per press.
    if (hold_tick_s) begin
      if ((hold_cnt_q == LONG_LAST) && !held_q) begin
        long_press_d = 1'b1;
        held_d       = 1'b1;
      end else begin
        long_press_d = 1'b0;
      end
      if (hold_cnt_q != LONG_LAST) begin
        hold_cnt_d = hold_cnt_q + CNT_ONE;
      end else begin
        hold_cnt_d = hold_cnt_q;
      end
    end else begin
      hold_cnt_d = hold_cnt_d;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      deb_cnt_q       <= CNT_ZERO;
      hold_cnt_q      <= CNT_ZERO;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_press_q    <= 1'b0;
      held_q          <= 1'b0;
      press_count_q   <= {PRESS_CNT_W{1'b0}};
    end else begin
      state_q         <= state_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_press_q    <= long_press_d;
      held_q          <= held_d;
      press_count_q   <= press_count_d;
    end
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_press    = long_press_q;
  assign held          = held_q;
  assign press_count   = press_count_q;

endmodule
